// File: rtl/axis_chan_sched.sv
// Round-robin scheduler that packs bytes from NUM_CH first-word-fall-through byte FIFOs
// into LOGIC_SIZE-bit AXI-Stream words, one channel per word, tagged with its source channel.
module axis_chan_sched #(
    parameter int LOGIC_SIZE = 32,
    parameter int NUM_CH     = 4
) (
    input  logic                      s_axis_aclk,
    input  logic                      s_axis_reset_n,
    input  logic [NUM_CH-1:0]         r_empty,
    input  logic [NUM_CH*8-1:0]       i_from_fifo,
    output logic [NUM_CH-1:0]         r_req,
    output logic [LOGIC_SIZE-1:0]     s_axis_tdata,
    output logic [$clog2(NUM_CH)-1:0] s_axis_tdest,
    output logic                      s_axis_valid,
    input  logic                      s_axis_ready
);

    localparam int BYTES = LOGIC_SIZE / 8;
    localparam int CNT_W = $clog2(BYTES);
    localparam int PTR_W = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

    // Output handshake: s_axis_valid is a pure function of state, so it never
    // depends on s_axis_ready; once raised it holds, with tdata/tdest stable,
    // until the edge where s_axis_valid && s_axis_ready completes the transfer.
    typedef enum logic [1:0] {IDLE, GATHER, SEND} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PTR_W-1:0]  grant;
    logic [PTR_W-1:0]  last_grant;
    logic [PTR_W-1:0]  pick;
    logic              found;
    logic [CNT_W-1:0]  cnt;
    logic [LOGIC_SIZE-1:0] word;
    logic              take;
    logic [7:0]        head;

    // First non-empty channel after the last granted one, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!found && !r_empty[(int'(last_grant) + i) % NUM_CH]) begin
                found = 1'b1;
                pick  = PTR_W'((int'(last_grant) + i) % NUM_CH);
            end
        end
    end

    assign head = i_from_fifo[int'(grant)*8 +: 8];
    assign take = (state == GATHER) && !r_empty[grant];

    always_comb begin
        r_req        = '0;
        r_req[grant] = take;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = GATHER;
            GATHER:  if (take && (cnt == LAST_CNT)) state_nxt = SEND;
            SEND:    if (s_axis_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_reset_n) begin
        if (!s_axis_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant is only reloaded from IDLE, so a stalled word keeps its channel.
    always_ff @(posedge s_axis_aclk or negedge s_axis_reset_n) begin
        if (!s_axis_reset_n) begin
            grant      <= '0;
            last_grant <= PTR_W'(NUM_CH - 1);
            cnt        <= '0;
            word       <= '0;
        end else begin
            if ((state == IDLE) && found) begin
                grant <= pick;
                cnt   <= '0;
            end
            if (take) begin
                word[int'(cnt)*8 +: 8] <= head;
                cnt <= (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
            end
            if ((state == SEND) && s_axis_ready) begin
                last_grant <= grant;
            end
        end
    end

    assign s_axis_valid = (state == SEND);
    assign s_axis_tdata = word;
    assign s_axis_tdest = grant;

endmodule

// File: tb/tb_axis_chan_sched.sv
// Bench for axis_chan_sched: byte-FIFO queues feed the channels, a queue of
// expected {tdest, tdata} words is checked at every handshake.
module tb_axis_chan_sched;

    localparam int LS    = 32;
    localparam int NCH   = 4;
    localparam int BYTES = LS / 8;
    localparam int PW    = $clog2(NCH);
    localparam int EW    = LS + PW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0]   r_empty;
    logic [NCH*8-1:0] i_from_fifo;
    logic [NCH-1:0]   r_req;
    logic [LS-1:0]    tdata;
    logic [PW-1:0]    tdest;
    logic             valid;
    logic             ready;

    axis_chan_sched #(.LOGIC_SIZE(LS), .NUM_CH(NCH)) dut (
        .s_axis_aclk    (clk),
        .s_axis_reset_n (rst_n),
        .r_empty        (r_empty),
        .i_from_fifo    (i_from_fifo),
        .r_req          (r_req),
        .s_axis_tdata   (tdata),
        .s_axis_tdest   (tdest),
        .s_axis_valid   (valid),
        .s_axis_ready   (ready)
    );

    logic [7:0]    fifo_q[NCH][$];
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [NCH-1:0] s_req;
    logic           s_valid;
    logic [LS-1:0]  s_data;
    logic [PW-1:0]  s_dest;

    typedef struct {
        int         ch;
        logic [7:0] b0, b1, b2, b3;
        logic [LS-1:0] exp_data;
        logic [PW-1:0] exp_dest;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        for (int c = 0; c < NCH; c++) begin
            r_empty[c] = (fifo_q[c].size() == 0);
            i_from_fifo[c*8 +: 8] = (fifo_q[c].size() == 0) ? 8'hee : fifo_q[c][0];
        end
    endtask

    // One clock: drive FIFO heads, sample just before the edge, pop after it.
    task automatic cyc();
        logic [EW-1:0] e;
        drive_fifo();
        @(negedge clk);
        #4;
        s_req   = r_req;
        s_valid = valid;
        s_data  = tdata;
        s_dest  = tdest;
        checks++;
        if ($countones(s_req) > 1 || (s_req & r_empty) != 0) begin
            errors++;
            $display("FAIL req_legal: got r_req=%b r_empty=%b", s_req, r_empty);
        end
        if (s_valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got dest=%0d data=%0h expected none", s_dest, s_data);
            end else begin
                e = exp_q.pop_front();
                check("xfer", {s_dest, s_data}, e);
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++)
            if (s_req[c] && fifo_q[c].size() > 0) void'(fifo_q[c].pop_front());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", valid, 0);
        check("rst_req", r_req, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tdest", tdest, 0);
        for (int c = 0; c < NCH; c++) fifo_q[c].delete();
        exp_q.delete();
        drive_fifo();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cyc();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_req, n_val, first, n;
        logic [LS-1:0] w;

        ready = 1'b1;
        drive_fifo();
        do_reset();

        for (int k = 0; k < 3; k++) begin
            cyc();
            check("idle_req", s_req, 0);
            check("idle_valid", s_valid, 0);
        end

        vecs[0] = '{0, 8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211, 2'd0};
        vecs[1] = '{3, 8'haa, 8'hbb, 8'hcc, 8'hdd, 32'hddccbbaa, 2'd3};
        vecs[2] = '{3, 8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201, 2'd3};
        vecs[3] = '{1, 8'hde, 8'had, 8'hbe, 8'hef, 32'hefbeadde, 2'd1};
        vecs[4] = '{2, 8'h00, 8'hff, 8'h00, 8'hff, 32'hff00ff00, 2'd2};

        for (int v = 0; v < 5; v++) begin
            fifo_q[vecs[v].ch].push_back(vecs[v].b0);
            fifo_q[vecs[v].ch].push_back(vecs[v].b1);
            fifo_q[vecs[v].ch].push_back(vecs[v].b2);
            fifo_q[vecs[v].ch].push_back(vecs[v].b3);
            exp_q.push_back({vecs[v].exp_dest, vecs[v].exp_data});
            n_req = 0;
            n_val = 0;
            first = -1;
            for (int k = 0; k < 8; k++) begin
                cyc();
                n_req += $countones(s_req);
                if (s_valid) begin
                    n_val++;
                    if (first < 0) first = k;
                end
            end
            check("vec_req_cycles", n_req, 4);
            check("vec_latency", first, 5);
            check("vec_valid_cycles", n_val, 1);
            check("vec_drained", exp_q.size(), 0);
        end

        // Fairness and throughput with every channel loaded.
        do_reset();
        cyc();
        check("post_rst_req", s_req, 0);
        check("post_rst_valid", s_valid, 0);
        for (int c = 0; c < NCH; c++)
            for (int j = 0; j < 8; j++) fifo_q[c].push_back(8'(c*16 + j));
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < BYTES; k++) w[k*8 +: 8] = 8'(c*16 + r*4 + k);
                exp_q.push_back({PW'(c), w});
            end
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            cyc();
            n++;
        end
        check("fair_drained", exp_q.size(), 0);
        check("fair_cycles", n, 48);

        // Mid-word stall on ch2 while ch0 waits.
        fifo_q[2].push_back(8'h5a);
        fifo_q[2].push_back(8'h6b);
        for (int k = 0; k < 3; k++) cyc();
        for (int k = 1; k <= 4; k++) fifo_q[0].push_back(8'(k));
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("stall_req", s_req, 0);
            check("stall_valid", s_valid, 0);
        end
        fifo_q[2].push_back(8'h7c);
        fifo_q[2].push_back(8'h8d);
        exp_q.push_back({2'd2, 32'h8d7c6b5a});
        exp_q.push_back({2'd0, 32'h04030201});
        drain("stall_drained", 40);

        // Backpressure: word held for 10 cycles with ready low.
        ready = 1'b0;
        fifo_q[1].push_back(8'ha1);
        fifo_q[1].push_back(8'hb2);
        fifo_q[1].push_back(8'hc3);
        fifo_q[1].push_back(8'hd4);
        exp_q.push_back({2'd1, 32'hd4c3b2a1});
        n = 0;
        do begin
            cyc();
            n++;
        end while (!s_valid && n < 20);
        check("bp_valid_seen", s_valid, 1);
        for (int k = 1; k <= 4; k++) fifo_q[0].push_back(8'he0 + 8'(k));
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("bp_valid", s_valid, 1);
            check("bp_data", {s_dest, s_data}, {2'd1, 32'hd4c3b2a1});
            check("bp_req", s_req, 0);
        end
        ready = 1'b1;
        cyc();
        check("bp_handshake", exp_q.size(), 0);
        cyc();
        check("bp_valid_drop", s_valid, 0);
        exp_q.push_back({2'd0, 32'he4e3e2e1});
        drain("bp_drained", 20);

        // Reset in the middle of gathering ch1 (three bytes taken).
        fifo_q[1].push_back(8'h10);
        fifo_q[1].push_back(8'h20);
        fifo_q[1].push_back(8'h30);
        fifo_q[1].push_back(8'h40);
        fifo_q[1].push_back(8'h50);
        for (int k = 0; k < 4; k++) cyc();
        drive_fifo();
        #1;
        check("mid_req_before", r_req, 4'b0010);
        check("mid_valid_before", valid, 0);
        do_reset();
        cyc();
        check("mid_post_req", s_req, 0);
        check("mid_post_valid", s_valid, 0);
        fifo_q[1].push_back(8'h61);
        fifo_q[1].push_back(8'h62);
        fifo_q[1].push_back(8'h63);
        fifo_q[1].push_back(8'h64);
        exp_q.push_back({2'd1, 32'h64636261});
        drain("mid_drained", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_chan_sched.md
AXIS_CHAN_SCHED -- requirements
Module: axis_chan_sched

Interface
REQ-001 Parameter LOGIC_SIZE, default 32, output word width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter NUM_CH, default 4, number of byte-FIFO source channels; SHALL be at least 2.
REQ-003 s_axis_aclk  input  1  block clock; all state SHALL be on its rising edge.
REQ-004 s_axis_reset_n  input  1  asynchronous, active-low reset.
REQ-005 r_empty  input  NUM_CH  per-channel byte-FIFO empty flag, bit c for channel c.
REQ-006 i_from_fifo  input  NUM_CH*8  per-channel FIFO head byte, channel c at [c*8 +: 8], first-word-fall-through (valid while r_empty[c]=0).
REQ-007 r_req  output  NUM_CH  per-channel read request; a byte is consumed at each edge where r_req[c]=1.
REQ-008 s_axis_tdata  output  LOGIC_SIZE  packed word.
REQ-009 s_axis_tdest  output  $clog2(NUM_CH)  source channel of the current word.
REQ-010 s_axis_valid  output  1  word valid.
REQ-011 s_axis_ready  input  1  downstream ready.

Function
REQ-012 BYTES = LOGIC_SIZE/8; byte counter width $clog2(BYTES); round-robin pointer width $clog2(NUM_CH).
REQ-013 FSM states: IDLE, GATHER, SEND; exactly one active at all times.
REQ-014 IDLE: if any r_empty bit is 0, grant the first non-empty channel searching from (last_grant+1) mod NUM_CH upward with wrap; register grant, clear byte counter, go to GATHER next cycle.
REQ-015 IDLE with all channels empty: remain in IDLE, r_req all 0.
REQ-016 GATHER: r_req[grant] = !r_empty[grant], combinational; all other r_req bits 0.
REQ-017 GATHER: at each edge with r_req[grant]=1, store i_from_fifo[grant] into word byte lane [cnt*8 +: 8] (byte 0 at [7:0], little-endian) and increment cnt.
REQ-018 GATHER with r_empty[grant]=1: stall, hold cnt and captured bytes, no r_req; grant SHALL NOT change until the word completes (no interleaving of channels within a word).
REQ-019 Capture at cnt = BYTES-1 SHALL transition to SEND on the same edge; cnt wraps to 0.
REQ-020 SEND: s_axis_valid=1, s_axis_tdata = packed word, s_axis_tdest = grant; r_req all 0.
REQ-021 SEND with s_axis_ready=0: hold valid, tdata and tdest stable (AXIS rule: valid never drops without a handshake).
REQ-022 SEND with s_axis_ready=1: handshake completes; last_grant <= grant; return to IDLE; valid 0 next cycle.
REQ-023 s_axis_valid SHALL be 0 in IDLE and GATHER; valid SHALL NOT depend combinationally on s_axis_ready.
REQ-024 At most one r_req bit SHALL be 1 in any cycle.
REQ-025 Minimum latency from grant to valid: BYTES cycles of GATHER after 1 IDLE cycle; sustained throughput: one word per BYTES+2 cycles with ready held high.
REQ-026 Fairness: with all channels continuously non-empty, grants SHALL rotate 0,1,...,NUM_CH-1,0,...

Reset
REQ-027 On reset assertion, immediately: state IDLE, s_axis_valid 0, r_req 0, cnt 0, grant 0, last_grant NUM_CH-1 (first search starts at channel 0), s_axis_tdata 0, s_axis_tdest 0.
REQ-028 Reset mid-GATHER or mid-SEND SHALL discard the partial or pending word; bytes already consumed are lost and not replayed.
REQ-029 Reset deassertion SHALL NOT generate r_req or valid in the first post-reset cycle unless a channel is non-empty, in which case the IDLE arbitration rule applies.

Verification
REQ-030 Ch0 preloaded 0x11,0x22,0x33,0x44, ready=1 -> r_req[0] for 4 cycles, then tdata=0x44332211, tdest=0, valid 1 cycle.
REQ-031 All 4 channels hold 8 bytes, ready=1 -> tdest sequence 0,1,2,3,0,1,2,3; no r_req overlap.
REQ-032 Ch2 has 2 bytes, then empty for 5 cycles, then 2 more -> stall with cnt=2 held, no other channel granted, one word with tdest=2.
REQ-033 Word pending, ready=0 for 10 cycles -> valid and tdata constant, r_req all 0; ready=1 -> single transfer.
REQ-034 Reset asserted with cnt=3 on ch1 -> valid 0, r_req 0 immediately; after release, ch1 refilled -> next word contains only post-reset bytes.
REQ-035 Only ch3 non-empty after last_grant=3 -> wrap search grants ch3 again, tdest=3.
